// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO: default word width,
// pointer width helper and the default pointer type.
package fifo_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_DEPTH = 4;

  // One extra MSB beyond the address bits serves as the wrap bit.
  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

  typedef logic [DEF_PTR_W-1:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// depth x n storage with a synchronous write port and a registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int n     = DEF_N,
  parameter int depth = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(depth)-1:0]   waddr,
  input  logic [n-1:0]               wdata,
  input  logic                       re,
  input  logic [$clog2(depth)-1:0]   raddr,
  output logic [n-1:0]               rdata
);

  logic [n-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read stage: rdata holds until the next accepted read
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO buffering the mux output word; wrap-bit pointers,
// registered count/status and one-cycle overflow/underflow pulses.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int n     = DEF_N,
  parameter int depth = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [n-1:0]             din,
  input  logic                     rd_en,
  output logic [n-1:0]             dout,
  output logic                     dout_vld,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count,
  output logic                     ovf,
  output logic                     udf
);

  localparam int pw = ptr_w(depth);
  localparam int aw = pw - 1;

  logic [pw-1:0] wr_ptr;
  logic [pw-1:0] rd_ptr;
  logic          rd_acc;
  logic          wr_acc;

  // Status derives only from pointer flops, so no input reaches it combinationally.
  assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
  assign empty = (wr_ptr == rd_ptr);

  // A read frees a slot in the same cycle, so a write to a full FIFO rides on it.
  assign rd_acc = en && rd_en && !empty;
  assign wr_acc = en && wr_en && (!full || rd_acc);

  fifo_mem #(
    .n     (n),
    .depth (depth)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr[aw-1:0]),
    .wdata (din),
    .re    (rd_acc && !rst),
    .raddr (rd_ptr[aw-1:0]),
    .rdata (dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + pw'(1);
      if (rd_acc) rd_ptr <= rd_ptr + pw'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + pw'(1);
        2'b01:   count <= count - pw'(1);
        default: count <= count;
      endcase
      dout_vld <= rd_acc;
      ovf      <= en && wr_en && full && !rd_acc;
      udf      <= en && rd_en && empty;
    end
  end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Parameterised single-clock FIFO that buffers the n-bit word selected by the upstream 2:1 mux stage.
- Decouples the mux output from a slower or stalled consumer.
- Provides full/empty/count status and one-cycle overflow/underflow flags.
- Sits directly downstream of the mux: the mux output feeds din, and the mux enable qualifies wr_en at top level.

Parameters:
- n, 8, data word width in bits (matches the mux width parameter).
- depth, 4, number of storage entries; must be a power of two, ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable; when 0, no state changes (except reset)
- wr_en  input  1  write request
- din  input  n  write data
- rd_en  input  1  read request
- dout  output  n  registered read data
- dout_vld  output  1  pulses high the cycle dout carries a newly read word
- full  output  1  high when count == depth
- empty  output  1  high when count == 0
- count  output  $clog2(depth)+1  number of stored words
- ovf  output  1  one-cycle pulse: write requested while full and not freed by a read
- udf  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: dout=0, dout_vld=0, full=0, empty=1, count=0, ovf=0, udf=0, both pointers=0. Memory contents are not cleared.
- Reset mid-operation: all stored words are discarded. Reset has priority over en and all requests.
- Pointers: wr_ptr and rd_ptr are each $clog2(depth)+1 bits wide.
  - The low bits index memory; the MSB is the wrap bit.
  - Both increment modulo 2*depth.
  - full = (addresses equal) AND (wrap bits differ).
  - empty = pointers equal.
- en = 0: pointers, count, memory and dout hold. dout_vld, ovf and udf are driven 0.
- Accepted read (rd_acc): en & rd_en & !empty.
  - Next edge: dout <= mem[rd_ptr], rd_ptr++, dout_vld=1.
  - Read latency is 1 cycle from the accepted request.
- Accepted write (wr_acc): en & wr_en & (!full | rd_acc).
  - Next edge: mem[wr_ptr] <= din, wr_ptr++.
- Write while full with a simultaneous accepted read: both are accepted, count unchanged.
- Read while empty with a simultaneous write: the read is rejected (no bypass), udf=1, and the write is accepted.
- Rejected read: dout holds its previous value, dout_vld=0.
- count updates: +1 on write only, -1 on read only, unchanged on both or neither.
- Flag timing: full, empty and count are registered and reflect state after the edge, so there are no combinational paths from inputs to status outputs.
- Error flags:
  - ovf = en & wr_en & full & !rd_acc, registered, one cycle.
  - udf = en & rd_en & empty, registered, one cycle.
  - The FIFO state is unchanged by a rejected request.
- Wrap-around: after 2*depth writes the pointer returns to 0 with no data loss.

Decomposition:
- Shared package fifo_pkg:
  - function/constant for pointer width, $clog2(depth)+1;
  - localparam default width of 8;
  - typedef for the ptr_t pointer type.
- One sub-module, fifo_mem:
  - depth×n storage array;
  - synchronous write port;
  - registered synchronous read port supplying dout.
- Pointer, count and flag logic stay in fifo_sync.

Test Plan (n=8, depth=4):
- Reset: assert rst for 2 cycles with wr_en=1 -> empty=1, full=0, count=0, dout=0, dout_vld=0, ovf=0.
- Fill to full: write 0xA1, 0xA2, 0xA3, 0xA4 -> count 1,2,3,4, full=1 after the 4th. A 5th write of 0xA5 -> ovf pulse for 1 cycle, count stays 4.
- Drain: four reads -> dout 0xA1..0xA4 each one cycle after its request, with dout_vld=1. Then empty=1; a 5th read -> udf=1, dout holds 0xA4, dout_vld=0.
- Simultaneous read/write while full: holding 0x10..0x13, write 0x14 and read in the same cycle -> dout=0x10, count stays 4, no ovf. The next reads return 0x11, 0x12, 0x13, 0x14.
- Wrap-around and en gating:
  - Stream 20 write-then-read pairs of invect (0..19) -> outputs are 0..19 in order.
  - Drop en for 3 cycles mid-stream while toggling wr_en/rd_en -> count and dout unchanged, no pulses.
- Reset mid-operation: with count=3, assert rst for 1 cycle -> empty=1, count=0. A subsequent write of 0x5A and read -> dout=0x5A.
